// File: rtl/bpsk_demodulator_pkg.sv
// bpsk_demodulator_pkg: shared widths, polarity constants and accumulator sizing for the BPSK receiver
package bpsk_demodulator_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int SAMPLES_PER_SYMBOL_DEFAULT = 64;
  localparam logic BIT_ZERO = 1'b0;
  localparam logic BIT_ONE = 1'b1;
  function automatic int acc_width(input int sps);
    return 2 * DATA_WIDTH + $clog2(sps) + 1;
  endfunction
endpackage

// File: rtl/bpsk_demodulator_integrate_dump.sv
// bpsk_demodulator_integrate_dump: integrates products over a symbol and strobes the finished sum
module bpsk_demodulator_integrate_dump
  import bpsk_demodulator_pkg::*;
#(
  parameter int ACC_WIDTH = acc_width(SAMPLES_PER_SYMBOL_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [2*DATA_WIDTH-1:0] prod,
  input  logic                          p_valid,
  input  logic                          p_first,
  input  logic                          p_last,
  output logic signed [ACC_WIDTH-1:0]    sum,
  output logic                          dump
);
  logic signed [ACC_WIDTH-1:0] ext;
  assign ext = ACC_WIDTH'(prod);
  // first product restarts the sum; dump marks the cycle the final sum is visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      dump <= 1'b0;
    end else begin
      dump <= p_valid && p_last;
      if (p_valid) sum <= p_first ? ext : sum + ext;
    end
  end
endmodule

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: correlates samples with the local carrier, integrates per symbol and slices to a bit
module bpsk_demodulator
  import bpsk_demodulator_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = SAMPLES_PER_SYMBOL_DEFAULT,
  parameter int ACC_WIDTH = acc_width(SAMPLES_PER_SYMBOL)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic signed [DATA_WIDTH-1:0] ref_in,
  input  logic                         sample_valid,
  input  logic                         sym_sync,
  output logic                         bit_out,
  output logic signed [ACC_WIDTH-1:0]  soft_out,
  output logic                         bit_valid,
  input  logic                         bit_ready,
  output logic                         overrun
);
  localparam int CW = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYMBOL - 1);
  logic [CW-1:0] count;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic p_valid, p_first, p_last, dump;
  logic signed [ACC_WIDTH-1:0] sum;
  // multiply stage with symbol position tracking; sym_sync restarts the symbol on this sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      prod    <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= sample_valid;
      if (sample_valid) begin
        prod    <= (2*DATA_WIDTH)'(sample_in) * (2*DATA_WIDTH)'(ref_in);
        p_first <= sym_sync || count == '0;
        p_last  <= !sym_sync && count == LAST;
        count   <= sym_sync ? CW'(1) : (count == LAST ? '0 : count + CW'(1));
      end
    end
  end
  bpsk_demodulator_integrate_dump #(.ACC_WIDTH(ACC_WIDTH)) u_integrate_dump (
    .clk     (clk),
    .reset   (reset),
    .prod    (prod),
    .p_valid (p_valid),
    .p_first (p_first),
    .p_last  (p_last),
    .sum     (sum),
    .dump    (dump)
  );
  // result register: a dump always loads; an unaccepted result being replaced flags overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      soft_out  <= '0;
      bit_out   <= BIT_ZERO;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (dump) begin
      soft_out  <= sum;
      bit_out   <= sum[ACC_WIDTH-1] ? BIT_ONE : BIT_ZERO;
      bit_valid <= 1'b1;
      if (bit_valid && !bit_ready) overrun <= 1'b1;
    end else if (bit_valid && bit_ready) begin
      bit_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator: scoreboard bench with a symbol-list reference model for the BPSK demodulator
module tb_bpsk_demodulator;
  import bpsk_demodulator_pkg::*;
  localparam int SPS = 4;
  localparam int AW = 2 * DATA_WIDTH + $clog2(SPS) + 1;
  typedef struct {longint sum; int due;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic signed [DATA_WIDTH-1:0] sample_in = '0, ref_in = '0;
  logic sample_valid = 1'b0, sym_sync = 1'b0, bit_ready = 1'b1;
  logic bit_out, bit_valid, overrun;
  logic signed [AW-1:0] soft_out;
  int vectors = 0, miscompares = 0, cyc = 0;
  exp_t q[$];
  longint cur[$];
  logic exp_ovr = 1'b0, seen = 1'b0;

  bpsk_demodulator #(.SAMPLES_PER_SYMBOL(SPS)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .ref_in(ref_in),
    .sample_valid(sample_valid), .sym_sync(sym_sync), .bit_out(bit_out),
    .soft_out(soft_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string n, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, got, want, cyc);
    end
  endfunction

  // monitor: results that were never accepted are superseded once the next one is due
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_ovr = 1'b0;
      seen = 1'b0;
      check("rst_valid", bit_valid, 0);
      check("rst_bit", bit_out, 0);
      check("rst_soft", soft_out, 0);
      check("rst_overrun", overrun, 0);
    end else begin
      while (q.size() > 1 && q[1].due <= cyc) begin
        q.delete(0);
        exp_ovr = 1'b1;
        seen = 1'b0;
      end
      if (bit_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: bit_valid=1 soft=%0d, expected no result (cycle %0d)", soft_out, cyc);
        end else begin
          if (!seen) begin
            check("latency", cyc, q[0].due);
            seen = 1'b1;
          end
          check("soft", soft_out, q[0].sum);
          check("bit", bit_out, q[0].sum < 0);
          check("overrun", overrun, exp_ovr);
          if (bit_ready) begin
            q.delete(0);
            seen = 1'b0;
          end
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_result: bit_valid=0, expected soft=%0d due cycle %0d (cycle %0d)", q[0].sum, q[0].due, cyc);
        q.delete(0);
        seen = 1'b0;
      end
    end
  end

  task automatic drive(input int s, input int r, input logic v, input logic sy);
    longint t;
    @(posedge clk);
    #1;
    sample_in = DATA_WIDTH'(s);
    ref_in = DATA_WIDTH'(r);
    sample_valid = v;
    sym_sync = sy;
    if (v) begin
      if (sy) cur.delete();
      cur.push_back(longint'(s) * longint'(r));
      if (cur.size() == SPS) begin
        t = 0;
        foreach (cur[i]) t += cur[i];
        q.push_back('{t, cyc + 3});
        cur.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    sample_valid = 1'b0;
    sym_sync = 1'b0;
    cur.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    idle(2);
    repeat (SPS) drive(1000, 1000, 1'b1, 1'b0);
    idle(4);
    repeat (SPS) drive(-1000, 1000, 1'b1, 1'b0);
    idle(4);
    repeat (SPS / 2) begin
      drive(2047, 2047, 1'b1, 1'b0);
      drive(-2047, 2047, 1'b1, 1'b0);
    end
    idle(4);
    bit_ready = 1'b0;
    repeat (SPS) drive(1000, 1000, 1'b1, 1'b0);
    idle(3);
    repeat (SPS) drive(-1000, 1000, 1'b1, 1'b0);
    idle(6);
    bit_ready = 1'b1;
    idle(3);
    do_reset();
    bit_ready = 1'b0;
    repeat (SPS) drive(700, -900, 1'b1, 1'b0);
    idle(3);
    repeat (SPS) drive(-300, -1200, 1'b1, 1'b0);
    idle(1);
    bit_ready = 1'b1;
    idle(5);
    for (int i = 0; i < SPS; i++) begin
      drive(rnd(), rnd(), 1'b1, 1'b0);
      idle(1);
    end
    idle(4);
    drive(rnd(), rnd(), 1'b1, 1'b0);
    drive(rnd(), rnd(), 1'b1, 1'b0);
    drive(500, 500, 1'b1, 1'b1);
    repeat (SPS - 1) drive(500, 500, 1'b1, 1'b0);
    idle(4);
    drive(1500, 1500, 1'b1, 1'b0);
    drive(1500, 1500, 1'b1, 1'b0);
    do_reset();
    repeat (SPS) drive(-1000, 1000, 1'b1, 1'b0);
    idle(4);
    for (int i = 0; i < 400; i++) begin
      bit_ready = ($urandom_range(0, 3) != 0);
      drive(rnd(), rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    bit_ready = 1'b1;
    idle(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
